axi4_master_bridge: RTL and testbench

- Converts the single-outstanding valid/ready memory request from the SoC address decoder (axi_* slave side) into single-beat AXI4 master transactions on m_axi_*.
- Sits directly downstream of the SoC interconnect and drives the external AXI4 interface.
- Registers each request so that a one-cycle valid pulse is sufficient.
- Returns rdata, a one-cycle ready pulse and an error flag.

---
 rtl/axi4_master_bridge.sv | 211 +++++++++++++++++++++
 tb/tb_axi4_master_bridge.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_master_bridge.sv
// axi4_master_bridge
// Turns a single-outstanding valid/ready memory request from the SoC
// interconnect into one single-beat AXI4 transaction on the m_axi_* master
// port. The request is registered on accept, so a one-cycle axi_valid pulse
// is enough. Completion is a one-cycle axi_ready pulse qualified by axi_error,
// with axi_rdata carrying read data (zero for writes).
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   axi_valid/instr/addr/    request side (sampled only while idle);
//   axi_wdata/wstrb          wstrb == 0 selects a read
//   axi_rdata/ready/error    completion side
//   m_axi_aw*/w*/b*          AXI4 write address, data and response channels
//   m_axi_ar*/r*             AXI4 read address and data channels
module axi4_master_bridge #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic        PROT_PRIV = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        axi_valid,
  input  logic        axi_instr,
  input  logic [31:0] axi_addr,
  input  logic [31:0] axi_wdata,
  input  logic [3:0]  axi_wstrb,
  output logic [31:0] axi_rdata,
  output logic        axi_ready,
  output logic        axi_error,
  output logic [31:0] m_axi_awaddr,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [7:0]  m_axi_awlen,
  output logic [2:0]  m_axi_awsize,
  output logic [1:0]  m_axi_awburst,
  output logic        m_axi_awlock,
  output logic [3:0]  m_axi_awcache,
  output logic [2:0]  m_axi_awprot,
  output logic [3:0]  m_axi_awqos,
  output logic [31:0] m_axi_wdata,
  output logic [3:0]  m_axi_wstrb,
  output logic        m_axi_wlast,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready,
  output logic [31:0] m_axi_araddr,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  output logic [7:0]  m_axi_arlen,
  output logic [2:0]  m_axi_arsize,
  output logic [1:0]  m_axi_arburst,
  output logic        m_axi_arlock,
  output logic [3:0]  m_axi_arcache,
  output logic [2:0]  m_axi_arprot,
  output logic [3:0]  m_axi_arqos,
  input  logic [31:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  input  logic        m_axi_rlast,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    WRESP = 3'd2,
    READ  = 3'd3,
    RRESP = 3'd4
  } state_t;

  state_t      state_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic [3:0]  wstrb_r;
  logic        instr_r;
  logic        awvalid_r;
  logic        wvalid_r;
  logic        bready_r;
  logic        arvalid_r;
  logic        rready_r;
  logic        ready_r;
  logic        error_r;
  logic [31:0] rdata_r;
  logic        aw_done_s;
  logic        w_done_s;
  logic        unused_rlast_s;

  // A channel counts as done if it finished earlier (valid already dropped)
  // or is handshaking this cycle, so AW and W may complete in either order.
  assign aw_done_s = ~awvalid_r | m_axi_awready;
  assign w_done_s  = ~wvalid_r  | m_axi_wready;

  // Single beats only; rlast carries no information for us.
  assign unused_rlast_s = m_axi_rlast;

  // Request FSM: accept, issue address/data, wait for response, pulse ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      addr_r    <= 32'h0000_0000;
      wdata_r   <= 32'h0000_0000;
      wstrb_r   <= 4'b0000;
      instr_r   <= 1'b0;
      awvalid_r <= 1'b0;
      wvalid_r  <= 1'b0;
      bready_r  <= 1'b0;
      arvalid_r <= 1'b0;
      rready_r  <= 1'b0;
      ready_r   <= 1'b0;
      error_r   <= 1'b0;
      rdata_r   <= 32'h0000_0000;
    end else begin
      ready_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (axi_valid) begin
            addr_r  <= axi_addr + BASE_ADDR;
            wdata_r <= axi_wdata;
            wstrb_r <= axi_wstrb;
            instr_r <= axi_instr;
            if (axi_wstrb != 4'b0000) begin
              state_r   <= WRITE;
              awvalid_r <= 1'b1;
              wvalid_r  <= 1'b1;
            end else begin
              state_r   <= READ;
              arvalid_r <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (awvalid_r && m_axi_awready) begin
            awvalid_r <= 1'b0;
          end
          if (wvalid_r && m_axi_wready) begin
            wvalid_r <= 1'b0;
          end
          if (aw_done_s && w_done_s) begin
            state_r  <= WRESP;
            bready_r <= 1'b1;
          end
        end
        WRESP: begin
          if (m_axi_bvalid) begin
            state_r  <= IDLE;
            bready_r <= 1'b0;
            ready_r  <= 1'b1;
            error_r  <= (m_axi_bresp != 2'b00);
            rdata_r  <= 32'h0000_0000;
          end
        end
        READ: begin
          if (m_axi_arready) begin
            state_r   <= RRESP;
            arvalid_r <= 1'b0;
            rready_r  <= 1'b1;
          end
        end
        RRESP: begin
          if (m_axi_rvalid) begin
            state_r  <= IDLE;
            rready_r <= 1'b0;
            ready_r  <= 1'b1;
            error_r  <= (m_axi_rresp != 2'b00);
            rdata_r  <= m_axi_rdata;
          end
        end
        default: begin
          state_r   <= IDLE;
          awvalid_r <= 1'b0;
          wvalid_r  <= 1'b0;
          bready_r  <= 1'b0;
          arvalid_r <= 1'b0;
          rready_r  <= 1'b0;
        end
      endcase
    end
  end

  assign axi_rdata = rdata_r;
  assign axi_ready = ready_r;
  assign axi_error = error_r;

  assign m_axi_awaddr  = addr_r;
  assign m_axi_awvalid = awvalid_r;
  assign m_axi_awlen   = 8'd0;
  assign m_axi_awsize  = 3'b010;
  assign m_axi_awburst = 2'b01;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = 4'b0011;
  assign m_axi_awprot  = {instr_r, 1'b0, PROT_PRIV};
  assign m_axi_awqos   = 4'd0;
  assign m_axi_wdata   = wdata_r;
  assign m_axi_wstrb   = wstrb_r;
  assign m_axi_wlast   = wvalid_r;
  assign m_axi_wvalid  = wvalid_r;
  assign m_axi_bready  = bready_r;

  assign m_axi_araddr  = addr_r;
  assign m_axi_arvalid = arvalid_r;
  assign m_axi_arlen   = 8'd0;
  assign m_axi_arsize  = 3'b010;
  assign m_axi_arburst = 2'b01;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = 4'b0011;
  assign m_axi_arprot  = {instr_r, 1'b0, PROT_PRIV};
  assign m_axi_arqos   = 4'd0;
  assign m_axi_rready  = rready_r;

endmodule

// File: tb/tb_axi4_master_bridge.sv
// Self-checking bench for axi4_master_bridge: directed scenarios with literal
// expectations, then randomized traffic against a transaction-level model.
module tb_axi4_master_bridge;
  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        axi_valid = 1'b0;
  logic        axi_instr = 1'b0;
  logic [31:0] axi_addr = 32'h0;
  logic [31:0] axi_wdata = 32'h0;
  logic [3:0]  axi_wstrb = 4'h0;
  logic [31:0] axi_rdata;
  logic        axi_ready, axi_error;
  logic [31:0] m_axi_awaddr;
  logic        m_axi_awvalid;
  logic        m_axi_awready = 1'b0;
  logic [7:0]  m_axi_awlen;
  logic [2:0]  m_axi_awsize;
  logic [1:0]  m_axi_awburst;
  logic        m_axi_awlock;
  logic [3:0]  m_axi_awcache;
  logic [2:0]  m_axi_awprot;
  logic [3:0]  m_axi_awqos;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wlast, m_axi_wvalid;
  logic        m_axi_wready = 1'b0;
  logic [1:0]  m_axi_bresp = 2'b00;
  logic        m_axi_bvalid = 1'b0;
  logic        m_axi_bready;
  logic [31:0] m_axi_araddr;
  logic        m_axi_arvalid;
  logic        m_axi_arready = 1'b0;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic        m_axi_arlock;
  logic [3:0]  m_axi_arcache;
  logic [2:0]  m_axi_arprot;
  logic [3:0]  m_axi_arqos;
  logic [31:0] m_axi_rdata = 32'h0;
  logic [1:0]  m_axi_rresp = 2'b00;
  logic        m_axi_rlast = 1'b0;
  logic        m_axi_rvalid = 1'b0;
  logic        m_axi_rready;

  axi4_master_bridge #(.BASE_ADDR(BASE), .PROT_PRIV(1'b1)) dut (
    .clk(clk), .rst(rst),
    .axi_valid(axi_valid), .axi_instr(axi_instr), .axi_addr(axi_addr),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
    .axi_rdata(axi_rdata), .axi_ready(axi_ready), .axi_error(axi_error),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
    .m_axi_awlock(m_axi_awlock), .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot),
    .m_axi_awqos(m_axi_awqos),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
    .m_axi_arlock(m_axi_arlock), .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot),
    .m_axi_arqos(m_axi_arqos),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Slave behaviour knobs (percent chance per cycle) and fixed-response mode.
  int          p_aw = 100, p_w = 100, p_ar = 100, p_resp = 100;
  bit          fix_en = 1'b0;
  logic [1:0]  fix_code = 2'b00;
  logic [31:0] fix_data = 32'h0;

  // Transaction-level model: one outstanding request, per-channel done flags.
  bit          started = 1'b0;
  bit          busy = 1'b0;
  bit          m_wr = 1'b0;
  bit          m_instr = 1'b0;
  bit          aw_done = 1'b0, w_done = 1'b0, ar_done = 1'b0;
  bit          pulse = 1'b0;
  bit          e_err = 1'b0;
  logic [31:0] m_addr = 32'h0, m_wdata = 32'h0, e_rdata = 32'h0;
  logic [3:0]  m_wstrb = 4'h0;
  int          ar_cnt = 0, aw_cnt = 0, rdy_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update at each active edge, from pre-edge values.
  always @(posedge clk) begin
    if (m_axi_arvalid === 1'b1 && m_axi_arready) ar_cnt++;
    if (m_axi_awvalid === 1'b1 && m_axi_awready) aw_cnt++;
    if (axi_ready === 1'b1) rdy_cnt++;
    pulse = 1'b0;
    if (rst) begin
      started = 1'b1;
      busy = 1'b0;
      aw_done = 1'b0; w_done = 1'b0; ar_done = 1'b0;
    end else if (!busy) begin
      if (axi_valid) begin
        busy = 1'b1;
        m_wr = (axi_wstrb != 4'h0);
        m_addr = axi_addr + BASE;
        m_wdata = axi_wdata;
        m_wstrb = axi_wstrb;
        m_instr = axi_instr;
        aw_done = 1'b0; w_done = 1'b0; ar_done = 1'b0;
      end
    end else if (m_wr) begin
      if (aw_done && w_done) begin
        if (m_axi_bvalid) begin
          busy = 1'b0; pulse = 1'b1;
          e_rdata = 32'h0; e_err = (m_axi_bresp != 2'b00);
        end
      end else begin
        if (!aw_done && m_axi_awready) aw_done = 1'b1;
        if (!w_done && m_axi_wready) w_done = 1'b1;
      end
    end else begin
      if (ar_done) begin
        if (m_axi_rvalid) begin
          busy = 1'b0; pulse = 1'b1;
          e_rdata = m_axi_rdata; e_err = (m_axi_rresp != 2'b00);
        end
      end else if (m_axi_arready) begin
        ar_done = 1'b1;
      end
    end
  end

  // Compare every cycle on the inactive edge.
  always @(negedge clk) begin
    if (started) begin
      chk("awvalid", 32'(m_axi_awvalid), 32'(busy && m_wr && !aw_done));
      chk("wvalid",  32'(m_axi_wvalid),  32'(busy && m_wr && !w_done));
      chk("bready",  32'(m_axi_bready),  32'(busy && m_wr && aw_done && w_done));
      chk("arvalid", 32'(m_axi_arvalid), 32'(busy && !m_wr && !ar_done));
      chk("rready",  32'(m_axi_rready),  32'(busy && !m_wr && ar_done));
      chk("axi_ready", 32'(axi_ready), 32'(pulse));
      chk("aw_consts", 32'({m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awlock, m_axi_awcache, m_axi_awqos}),
          32'({8'd0, 3'b010, 2'b01, 1'b0, 4'b0011, 4'd0}));
      chk("ar_consts", 32'({m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arlock, m_axi_arcache, m_axi_arqos}),
          32'({8'd0, 3'b010, 2'b01, 1'b0, 4'b0011, 4'd0}));
      if (busy && m_wr && !aw_done) begin
        chk("awaddr", m_axi_awaddr, m_addr);
        chk("awprot", 32'(m_axi_awprot), 32'({m_instr, 1'b0, 1'b1}));
      end
      if (busy && m_wr && !w_done) begin
        chk("wdata", m_axi_wdata, m_wdata);
        chk("wstrb", 32'(m_axi_wstrb), 32'(m_wstrb));
        chk("wlast", 32'(m_axi_wlast), 32'd1);
      end
      if (busy && !m_wr && !ar_done) begin
        chk("araddr", m_axi_araddr, m_addr);
        chk("arprot", 32'(m_axi_arprot), 32'({m_instr, 1'b0, 1'b1}));
      end
      if (pulse) begin
        chk("rdata", axi_rdata, e_rdata);
        chk("error", 32'(axi_error), 32'(e_err));
      end
    end
  end

  // One clock: wait for the edge, then drive the slave side and drop axi_valid.
  task automatic cycle();
    @(posedge clk);
    #1;
    axi_valid = 1'b0;
    m_axi_awready = ($urandom_range(99) < p_aw);
    m_axi_wready  = ($urandom_range(99) < p_w);
    m_axi_arready = ($urandom_range(99) < p_ar);
    m_axi_rlast   = 1'($urandom_range(1));
    if (busy && m_wr && aw_done && w_done) begin
      if (!m_axi_bvalid && $urandom_range(99) < p_resp) begin
        m_axi_bvalid = 1'b1;
        m_axi_bresp  = fix_en ? fix_code : 2'($urandom_range(3));
      end
    end else begin
      m_axi_bvalid = 1'b0;
    end
    if (busy && !m_wr && ar_done) begin
      if (!m_axi_rvalid && $urandom_range(99) < p_resp) begin
        m_axi_rvalid = 1'b1;
        m_axi_rresp  = fix_en ? fix_code : 2'($urandom_range(3));
        m_axi_rdata  = fix_en ? fix_data : $urandom();
      end
    end else begin
      m_axi_rvalid = 1'b0;
    end
  endtask

  task automatic request(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic ins);
    axi_valid = 1'b1;
    axi_addr  = a;
    axi_wdata = d;
    axi_wstrb = s;
    axi_instr = ins;
  endtask

  // Step until axi_ready is seen; n = edges stepped after the accept edge.
  task automatic wait_ready(output int n);
    n = 0;
    while (axi_ready !== 1'b1 && n < 300) begin
      cycle();
      n++;
    end
    if (axi_ready !== 1'b1) chk("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic set_all(input int p);
    p_aw = p; p_w = p; p_ar = p; p_resp = p;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n, a0, w0, r0;
    repeat (3) cycle();
    rst = 1'b0;
    chk("reset_outs", 32'({m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid,
                          m_axi_rready, axi_ready, axi_error}), 32'd0);
    chk("reset_rdata", axi_rdata, 32'd0);

    // Read against an always-ready slave.
    set_all(100); fix_en = 1'b1; fix_code = 2'b00; fix_data = 32'hDEAD_BEEF;
    request(32'h10, 32'h0, 4'h0, 1'b0);
    cycle();
    chk("d1_arvalid", 32'(m_axi_arvalid), 32'd1);
    chk("d1_araddr", m_axi_araddr, 32'h8000_0010);
    chk("d1_arprot", 32'(m_axi_arprot), 32'd1);
    wait_ready(n);
    chk("d1_latency", 32'(n + 1), 32'd3);
    chk("d1_rdata", axi_rdata, 32'hDEAD_BEEF);
    chk("d1_error", 32'(axi_error), 32'd0);
    cycle();
    chk("d1_pulse_width", 32'(axi_ready), 32'd0);

    // Write where W is accepted well before AW.
    p_aw = 0; p_w = 100;
    request(32'h40, 32'h1234_5678, 4'b0011, 1'b0);
    cycle();
    cycle();
    chk("d2_wvalid_dropped", 32'(m_axi_wvalid), 32'd0);
    chk("d2_awvalid_held", 32'(m_axi_awvalid), 32'd1);
    cycle();
    cycle();
    chk("d2_awvalid_still", 32'(m_axi_awvalid), 32'd1);
    chk("d2_awaddr", m_axi_awaddr, 32'h8000_0040);
    p_aw = 100;
    r0 = rdy_cnt;
    wait_ready(n);
    chk("d2_rdata", axi_rdata, 32'd0);
    cycle();
    cycle();
    chk("d2_one_pulse", 32'(rdy_cnt - r0), 32'd1);

    // Error responses.
    fix_code = 2'b10; fix_data = 32'h0000_00AA;
    request(32'h4, 32'h0, 4'h0, 1'b0);
    cycle();
    wait_ready(n);
    chk("d3_rd_error", 32'(axi_error), 32'd1);
    chk("d3_rd_rdata", axi_rdata, 32'h0000_00AA);
    fix_code = 2'b11;
    request(32'h8, 32'hCAFE_0001, 4'hF, 1'b0);
    cycle();
    wait_ready(n);
    chk("d3_wr_error", 32'(axi_error), 32'd1);
    chk("d3_wr_rdata", axi_rdata, 32'd0);
    cycle();

    // AR backpressure with spurious requests in flight.
    fix_code = 2'b00; p_ar = 0;
    a0 = ar_cnt; w0 = aw_cnt;
    request(32'h100, 32'h0, 4'h0, 1'b0);
    cycle();
    for (int i = 0; i < 10; i++) begin
      chk("d4_arvalid", 32'(m_axi_arvalid), 32'd1);
      chk("d4_araddr", m_axi_araddr, 32'h8000_0100);
      if (i % 2 == 1) request($urandom(), $urandom(), 4'hF, 1'b0);
      cycle();
    end
    p_ar = 100;
    wait_ready(n);
    cycle();
    chk("d4_one_ar", 32'(ar_cnt - a0), 32'd1);
    chk("d4_no_aw", 32'(aw_cnt - w0), 32'd0);

    // Reset while waiting for B.
    p_resp = 0;
    request(32'h200, 32'h5555_AAAA, 4'h1, 1'b0);
    cycle();
    n = 0;
    while (m_axi_bready !== 1'b1 && n < 50) begin cycle(); n++; end
    chk("d5_in_wresp", 32'(m_axi_bready), 32'd1);
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("d5_reset_outs", 32'({m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid,
                             m_axi_rready, axi_ready, axi_error}), 32'd0);
    p_resp = 100; fix_data = 32'h0BAD_F00D;
    request(32'h300, 32'h0, 4'h0, 1'b0);
    cycle();
    wait_ready(n);
    chk("d5_read_after_reset", axi_rdata, 32'h0BAD_F00D);

    // Instruction fetch followed by a write accepted on the ready pulse.
    fix_data = 32'h1357_9BDF;
    request(32'h20, 32'h0, 4'h0, 1'b1);
    cycle();
    chk("d6_arprot", 32'(m_axi_arprot), 32'd5);
    wait_ready(n);
    chk("d6_fetch_rdata", axi_rdata, 32'h1357_9BDF);
    request(32'h24, 32'h8765_4321, 4'hF, 1'b0);
    cycle();
    chk("d6_no_bubble", 32'(m_axi_awvalid), 32'd1);
    chk("d6_awprot", 32'(m_axi_awprot), 32'd1);
    wait_ready(n);
    cycle();

    // Randomized traffic, checked cycle by cycle against the model.
    fix_en = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      if (t % 250 == 0) begin
        p_aw = $urandom_range(100, 20); p_w = $urandom_range(100, 20);
        p_ar = $urandom_range(100, 20); p_resp = $urandom_range(100, 20);
      end
      if ((!busy && $urandom_range(1) == 1) || (busy && $urandom_range(9) == 0)) begin
        request($urandom(), $urandom(),
                ($urandom_range(1) == 1) ? 4'h0 : 4'($urandom_range(15, 1)),
                1'($urandom_range(1)));
      end
      cycle();
    end
    set_all(100);
    n = 0;
    while (busy && n < 200) begin cycle(); n++; end
    chk("drain_idle", 32'(busy), 32'd0);
    cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
